// File: rtl/tst_dout_pkg.sv
// tst_dout_pkg: shared widths, window constants and FSM encoding for the tst_dout statistics source.
package tst_dout_pkg;
    localparam int WIN   = 64;
    localparam int CNT_W = 7;
    localparam int IDL_W = 12;
    localparam int LAT_W = 16;
    localparam int TOT_W = 48;
    localparam int WC_W  = 6;
    localparam logic [WC_W-1:0] FLUSH_LAST = 6'd63;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/tst_dout_win_acc.sv
// tst_dout_win_acc: per-window sample/error/idle accumulators with a held snapshot and toggle strobe.
module tst_dout_win_acc
    import tst_dout_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             publish,
    input  logic [2:0]       inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] err,
    output logic [IDL_W-1:0] idl,
    output logic             tgl
);
    logic [CNT_W-1:0] a_cnt, a_err, a_idl;
    logic [CNT_W-1:0] n_cnt, n_err, n_idl;
    always_comb begin
        n_cnt = a_cnt + CNT_W'(inc[0]);
        n_err = a_err + CNT_W'(inc[1]);
        n_idl = a_idl + CNT_W'(inc[2]);
    end
    // the snapshot takes the publishing cycle's contribution so boundary samples land exactly once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {a_cnt, a_err, a_idl, cnt, err, idl, tgl} <= '0;
        end else if (clr) begin
            {a_cnt, a_err, a_idl} <= '0;
        end else if (publish) begin
            cnt <= n_cnt;
            err <= n_err;
            idl <= IDL_W'(n_idl);
            tgl <= ~tgl;
            {a_cnt, a_err, a_idl} <= '0;
        end else begin
            a_cnt <= n_cnt;
            a_err <= n_err;
            a_idl <= n_idl;
        end
    end
endmodule

// File: rtl/tst_dout_stats_src.sv
// tst_dout_stats_src: windowed test statistics with toggle-strobed snapshots for a slow-clock accumulator.
module tst_dout_stats_src #(
    parameter int WIN   = tst_dout_pkg::WIN,
    parameter int N_SMP = 2**20,
    parameter int TOT_W = tst_dout_pkg::TOT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        test_en,
    input  logic        smp_vld_i,
    input  logic        smp_err_i,
    output logic        vld_o,
    output logic [6:0]  cnt_o,
    output logic [6:0]  err_o,
    output logic [11:0] idl_o,
    output logic [15:0] lat_o,
    output logic        done_o
);
    import tst_dout_pkg::*;
    localparam logic [WC_W-1:0]  W_LAST = WC_W'(WIN - 1);
    localparam logic [TOT_W-1:0] T_LAST = TOT_W'(N_SMP - 1);
    state_t state, nxt;
    logic [1:0] ten_q;
    logic ten_d, start, stop, act, hit, publish, clr;
    logic [2:0] inc;
    logic [WC_W-1:0] wcnt;
    logic [TOT_W-1:0] total;
    logic [LAT_W-1:0] lat_ctr;
    always_comb begin
        start   = ten_q[1] && !ten_d;
        stop    = !ten_q[1] && ten_d;
        act     = state == S_WAIT || state == S_RUN;
        hit     = act && smp_vld_i && total == T_LAST;
        publish = act && (wcnt == W_LAST || hit || stop);
        clr     = state == S_IDLE && start;
        inc     = act ? {state == S_RUN && !smp_vld_i, smp_vld_i && smp_err_i, smp_vld_i} : 3'b000;
        nxt     = state;
        case (state)
            S_IDLE:  nxt = start ? S_WAIT : S_IDLE;
            S_WAIT:  nxt = stop ? S_IDLE : hit ? S_FLUSH : smp_vld_i ? S_RUN : S_WAIT;
            S_RUN:   nxt = stop ? S_IDLE : hit ? S_FLUSH : S_RUN;
            S_FLUSH: nxt = stop ? S_IDLE : wcnt == FLUSH_LAST ? S_DONE : S_FLUSH;
            S_DONE:  nxt = stop ? S_IDLE : S_DONE;
            default: nxt = S_IDLE;
        endcase
    end
    // wcnt doubles as the quiet-cycle counter once the final partial window is out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ten_q   <= '0;
            ten_d   <= 1'b0;
            wcnt    <= '0;
            total   <= '0;
            lat_ctr <= '0;
            lat_o   <= '0;
            done_o  <= 1'b0;
        end else begin
            ten_q  <= {ten_q[0], test_en};
            ten_d  <= ten_q[1];
            state  <= nxt;
            done_o <= !stop && ((state == S_FLUSH && wcnt == FLUSH_LAST) || state == S_DONE);
            if (publish) lat_o <= lat_ctr;
            if (clr) begin
                wcnt    <= '0;
                total   <= '0;
                lat_ctr <= '0;
            end else if (act) begin
                wcnt  <= (hit || wcnt == W_LAST) ? '0 : wcnt + 1'b1;
                total <= total + TOT_W'(smp_vld_i);
                if (state == S_WAIT && !smp_vld_i && !(&lat_ctr)) lat_ctr <= lat_ctr + 1'b1;
            end else if (state == S_FLUSH) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end
    tst_dout_win_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .publish (publish),
        .inc     (inc),
        .cnt     (cnt_o),
        .err     (err_o),
        .idl     (idl_o),
        .tgl     (vld_o)
    );
endmodule

// File: tb/tb_tst_dout_stats_src.sv
// tb_tst_dout_stats_src: scoreboard bench; expected windows come from a per-test window model.
module tb_tst_dout_stats_src;
    localparam int N = 256;
    localparam int MAXT = 70400;
    typedef struct {int c; int e; int i; int l;} win_t;
    logic clk = 0, rst = 1, test_en = 0, smp_vld_i = 0, smp_err_i = 0;
    logic vld_o, done_o;
    logic [6:0] cnt_o, err_o;
    logic [11:0] idl_o;
    logic [15:0] lat_o;
    win_t q[$];
    win_t mw;
    bit vv[MAXT];
    bit ee[MAXT];
    int n_cmp = 0, n_bad = 0;
    logic prev = 0;

    always #5 clk = ~clk;

    tst_dout_stats_src #(.N_SMP(N)) dut (
        .clk(clk), .rst(rst), .test_en(test_en), .smp_vld_i(smp_vld_i), .smp_err_i(smp_err_i),
        .vld_o(vld_o), .cnt_o(cnt_o), .err_o(err_o), .idl_o(idl_o), .lat_o(lat_o), .done_o(done_o)
    );

    function automatic int sat(input int v);
        return v > 65535 ? 65535 : v;
    endfunction

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
        end
    endtask

    // each toggle of vld_o must present the oldest outstanding expected window
    always @(negedge clk) begin
        if (rst) prev = vld_o;
        else if (vld_o !== prev) begin
            prev = vld_o;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_toggle: cnt=%0d err=%0d idl=%0d lat=%0d with nothing expected", cnt_o, err_o, idl_o, lat_o);
            end else begin
                mw = q.pop_front();
                if (cnt_o != mw.c[6:0] || err_o != mw.e[6:0] || idl_o != mw.i[11:0] || lat_o != mw.l[15:0]) begin
                    n_bad++;
                    $display("FAIL window: got cnt=%0d err=%0d idl=%0d lat=%0d expected cnt=%0d err=%0d idl=%0d lat=%0d",
                             cnt_o, err_o, idl_o, lat_o, mw.c, mw.e, mw.i, mw.l);
                end
            end
        end
    end

    task automatic fill(input int first, input int every, input int pct, input int epct);
        for (int t = 0; t < MAXT; t++) begin
            vv[t] = t >= first && (t - first) % every == 0 && $urandom_range(99, 0) < pct;
            ee[t] = $urandom_range(99, 0) < epct;
        end
    endtask

    // windows over cycle index t relative to test start; idles count only after the first sample
    task automatic model(input int T, input int stop, output int tN);
        int first, ns, c, e, i;
        win_t w;
        first = -1; ns = 0; c = 0; e = 0; i = 0; tN = -1;
        for (int t = 0; t < T; t++) begin
            if (first < 0 && vv[t]) first = t;
            if (first >= 0) begin
                if (vv[t]) begin c++; ns++; e += int'(ee[t]); end
                else i++;
            end
            if (t % 64 == 63 || ns == N || t == stop) begin
                w.c = c; w.e = e; w.i = i; w.l = first >= 0 ? sat(first) : sat(t);
                q.push_back(w);
                c = 0; e = 0; i = 0;
            end
            if (ns == N) begin tN = t; break; end
            if (t == stop) break;
        end
    endtask

    task automatic cyc(input bit v, input bit e);
        smp_vld_i = v;
        smp_err_i = e;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int T, input int stop);
        int tN;
        model(T, stop, tN);
        test_en = 1;
        repeat (3) cyc(0, 0);
        for (int t = 0; t < T; t++) begin
            if (t == stop - 2) test_en = 0;
            cyc(vv[t], ee[t]);
            if (tN >= 0 && (stop < 0 || stop > tN + 66)) begin
                if (t + 1 == tN + 64) check("done_early", done_o, 0);
                if (t + 1 == tN + 65) check("done_set", done_o, 1);
            end
        end
    endtask

    task automatic drain();
        repeat (80) cyc(0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        q.delete();
        check("done_clear", done_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {vld_o, cnt_o, err_o, idl_o, lat_o, done_o}, 0);
        rst = 0;
        repeat (5) cyc(0, 0);
        fill(10, 1, 100, 12);
        run(401, 400);
        drain();
        fill(0, 1, 100, 0);
        ee[3] = 1; ee[64] = 1; ee[65] = 1;
        run(401, 400);
        drain();
        fill(0, 4, 100, 30);
        run(1100, 1095);
        drain();
        fill(0, 1, 60, 20);
        run(149, 148);
        drain();
        fill(5, 1, 100, 10);
        run(401, 400);
        drain();
        fill(MAXT, 1, 100, 0);
        run(70000, 69999);
        drain();
        fill(0, 1, 70, 20);
        run(100, -1);
        test_en = 0;
        #2 rst = 1;
        #1 check("async_reset_outputs", {vld_o, cnt_o, err_o, idl_o, lat_o, done_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (10) cyc(0, 0);
        check("reset_queue_drained", q.size(), 0);
        q.delete();
        fill(10, 1, 100, 12);
        run(401, 400);
        drain();
        for (int k = 0; k < 3; k++) begin
            int stop;
            fill($urandom_range(20, 0), 1, $urandom_range(100, 40), 20);
            stop = $urandom_range(700, 30);
            run(stop + 1, stop);
            drain();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
